// File: rtl/multiplier_control_pkg.sv
// Shared types and constants for the shift-add multiplier control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: ctrl_state_t (sequencer states), MULT_WIDTH (default operand width).
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADD,
    SHIFT,
    HOLD
  } ctrl_state_t;

endpackage

// File: rtl/multiplier_control_if.sv
// Button/datapath bundle between the input synchronizers, the sequencer and the datapath.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle commands with no acknowledge.
//
// master: drives Run, ClearA_LoadB, M (and Step when MULT_CTRL_STEP_EN), reads strobes/status.
// slave : the controller; reads buttons and M, drives Ld_B/Clr_A/Add/Sub/Shift/Busy/Done/Count.
interface multiplier_control_if #(
  parameter int CNT_W = 3
);
  logic             Run;
  logic             ClearA_LoadB;
  logic             M;
`ifdef MULT_CTRL_STEP_EN
  logic             Step;
`endif
  logic             Ld_B;
  logic             Clr_A;
  logic             Add;
  logic             Sub;
  logic             Shift;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Count;

`ifdef MULT_CTRL_STEP_EN
  modport master (
    output Run, ClearA_LoadB, M, Step,
    input  Ld_B, Clr_A, Add, Sub, Shift, Busy, Done, Count
  );
  modport slave (
    input  Run, ClearA_LoadB, M, Step,
    output Ld_B, Clr_A, Add, Sub, Shift, Busy, Done, Count
  );
`else
  modport master (
    output Run, ClearA_LoadB, M,
    input  Ld_B, Clr_A, Add, Sub, Shift, Busy, Done, Count
  );
  modport slave (
    input  Run, ClearA_LoadB, M,
    output Ld_B, Clr_A, Add, Sub, Shift, Busy, Done, Count
  );
`endif

endinterface

// File: rtl/multiplier_control_edge_detect.sv
// Rising-edge detector for an already-synchronized button level.
// Latency: rise_o is combinational from sig_i (same cycle as the new level).
// Backpressure: none.
//
// Ports: clk_i, rst_ni (sync, active-low), sig_i (level), rise_o (one-cycle pulse).
// The delay flop resets to 1 so a button held through reset never looks like a press.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/multiplier_control.sv
// Sequencer turning Run / ClearA_LoadB presses into shift-add multiplier datapath strobes.
// Latency: START one cycle after the Run edge, HOLD 1 + 2*WIDTH cycles after START.
// Backpressure: none; a new Run press is only honoured back in IDLE, ClearA_LoadB ignored while Busy.
//
// Ports: Clk, Reset_n (sync, active-low), bus (multiplier_control_if.slave).
// Optional: define MULT_CTRL_STEP_EN to single-step ADD/SHIFT phases on Step rising edges.
module multiplier_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  multiplier_control_if.slave  bus
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             run_rise;
  logic             adv;       // ADD/SHIFT may complete this cycle
  logic             last_iter; // sign bit of the multiplier

  edge_detect u_run_edge (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .sig_i  (bus.Run),
    .rise_o (run_rise)
  );

`ifdef MULT_CTRL_STEP_EN
  logic step_rise;

  edge_detect u_step_edge (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .sig_i  (bus.Step),
    .rise_o (step_rise)
  );

  assign adv = step_rise;
`else
  assign adv = 1'b1;
`endif

  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        // a load request masks a simultaneous Run press
        if (!bus.ClearA_LoadB && run_rise) state_d = START;
      end
      START: begin
        count_d = '0;
        state_d = ADD;
      end
      ADD: begin
        if (adv) state_d = SHIFT;
      end
      SHIFT: begin
        if (adv) begin
          if (last_iter) begin
            count_d = '0;
            state_d = HOLD;
          end else begin
            count_d = count_q + CNT_W'(1);
            state_d = ADD;
          end
        end
      end
      HOLD: begin
        if (!bus.Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  logic ld_b, clr_a, add, sub, shift, busy, done;

  always_comb begin
    ld_b  = 1'b0;
    clr_a = 1'b0;
    add   = 1'b0;
    sub   = 1'b0;
    shift = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      IDLE:  ld_b = bus.ClearA_LoadB;
      START: begin
        clr_a = 1'b1;
        busy  = 1'b1;
      end
      ADD: begin
        // the final bit carries negative weight in two's complement
        add  = adv & bus.M & ~last_iter;
        sub  = adv & bus.M & last_iter;
        busy = 1'b1;
      end
      SHIFT: begin
        shift = adv;
        busy  = 1'b1;
      end
      HOLD: begin
        done = 1'b1;
        ld_b = bus.ClearA_LoadB;
      end
      default: ;
    endcase
  end

  assign bus.Ld_B  = ld_b;
  assign bus.Clr_A = clr_a;
  assign bus.Add   = add;
  assign bus.Sub   = sub;
  assign bus.Shift = shift;
  assign bus.Busy  = busy;
  assign bus.Done  = done;
  assign bus.Count = count_q;

endmodule
